// File: rtl/jmb_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package jmb_mul_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter has to hold the value WIDTH itself, so it needs one bit more than log2.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/jmb_mul_seq_if.sv
// Operand/result handshake bundle between the producer/consumer and the multiplier.
interface jmb_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     mult_1;
    logic [WIDTH-1:0]     mult_2;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   prod;
    logic                 busy;

    // Producer/consumer side
    modport master (
        output in_valid, mult_1, mult_2, is_signed, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, mult_1, mult_2, is_signed, out_ready,
        output in_ready, out_valid, prod, busy
    );
endinterface

// File: rtl/jmb_mul_sgn.sv
// Conditional two's-complement negation. Used on the operands to take
// magnitudes and on the result to restore the sign.
module jmb_mul_sgn #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);
    // Negating the most negative value wraps back onto itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/jmb_mul_seq.sv
// Multi-cycle shift-add multiplier with valid/ready handshakes on both sides.
// Works on magnitudes and applies the sign once at the end, so the latency is
// exactly WIDTH RUN edges regardless of operand values or mode.
module jmb_mul_seq
    import jmb_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    jmb_mul_seq_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_t             state_q;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [PW-1:0]      prod_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [PW-1:0]      acc_d;
    logic [PW-1:0]      prod_d;
    logic               neg_a;
    logic               neg_b;

    assign neg_a = bus.is_signed & bus.mult_1[WIDTH-1];
    assign neg_b = bus.is_signed & bus.mult_2[WIDTH-1];

    jmb_mul_sgn #(.WIDTH(WIDTH)) u_mag_a (.val_i(bus.mult_1), .neg_i(neg_a), .res_o(mag_a));
    jmb_mul_sgn #(.WIDTH(WIDTH)) u_mag_b (.val_i(bus.mult_2), .neg_i(neg_b), .res_o(mag_b));
    jmb_mul_sgn #(.WIDTH(PW))    u_res   (.val_i(acc_d),      .neg_i(neg_q), .res_o(prod_d));

    // Accumulator next value: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // Controller, datapath registers and registered handshake outputs.
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Every register is cleared; there is no storage array here that would justify skipping it.
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            prod_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q    <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q   <= mag_b;
                        neg_q      <= neg_a ^ neg_b;
                        acc_q      <= '0;
                        cnt_q      <= CNT_W'(WIDTH);
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= ST_DONE;
                        prod_q      <= prod_d;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready stays low on this edge, so a new pair waits one more edge.
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.prod      = prod_q;

endmodule

// File: tb/tb_jmb_mul_seq.sv
// Directed self-checking bench for jmb_mul_seq (WIDTH = 8).
module tb_jmb_mul_seq;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    jmb_mul_seq_if #(.WIDTH(8)) bus ();

    jmb_mul_seq #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a pair, let it be accepted, then scramble the inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        check({tag, ":in_ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.mult_1    = a;
        bus.mult_2    = b;
        bus.is_signed = s;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        check({tag, ":busy_after_accept"}, 32'(bus.busy), 32'd1);
        check({tag, ":in_ready_after_accept"}, 32'(bus.in_ready), 32'd0);
        bus.mult_1    = ~a;
        bus.mult_2    = b ^ 8'h5A;
        bus.is_signed = ~s;
    endtask

    // Count edges until out_valid, then check latency and product.
    task automatic wait_done(input logic [15:0] exp, input string tag);
        int   lat     = 0;
        logic ir_high = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
            if (bus.in_ready !== 1'b0) ir_high = 1'b1;
        end
        check({tag, ":latency"}, 32'(lat), 32'd8);
        check({tag, ":in_ready_low_in_run"}, 32'(ir_high), 32'd0);
        check({tag, ":prod"}, 32'(bus.prod), 32'(exp));
    endtask

    // Consume the result and confirm return to IDLE with prod retained.
    task automatic release_op(input logic [15:0] exp, input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ":out_valid_cleared"}, 32'(bus.out_valid), 32'd0);
        check({tag, ":in_ready_back"}, 32'(bus.in_ready), 32'd1);
        check({tag, ":busy_cleared"}, 32'(bus.busy), 32'd0);
        check({tag, ":prod_retained"}, 32'(bus.prod), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mult_1    = '0;
        bus.mult_2    = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset / idle state
        check("rst:in_ready", 32'(bus.in_ready), 32'd1);
        check("rst:out_valid", 32'(bus.out_valid), 32'd0);
        check("rst:prod", 32'(bus.prod), 32'h0000);
        check("rst:busy", 32'(bus.busy), 32'd0);

        // Unsigned basics
        start_op(8'd2, 8'd3, 1'b0, "u2x3");
        wait_done(16'h0006, "u2x3");
        release_op(16'h0006, "u2x3");

        start_op(8'd15, 8'd4, 1'b0, "u15x4");
        wait_done(16'd60, "u15x4");
        release_op(16'd60, "u15x4");

        // Signed -3*5 with backpressure and a held next request
        start_op(8'hFD, 8'h05, 1'b1, "sm3x5");
        wait_done(16'hFFF1, "sm3x5");
        bus.mult_1    = 8'd3;
        bus.mult_2    = 8'd7;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp:out_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp:prod_held", 32'(bus.prod), 32'hFFF1);
            check("bp:in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        release_op(16'hFFF1, "bp");
        start_op(8'd3, 8'd7, 1'b0, "held3x7");
        wait_done(16'h0015, "held3x7");
        release_op(16'h0015, "held3x7");

        // Signed corners
        start_op(8'h80, 8'h80, 1'b1, "sm128xm128");
        wait_done(16'h4000, "sm128xm128");
        release_op(16'h4000, "sm128xm128");

        start_op(8'h80, 8'h7F, 1'b1, "sm128x127");
        wait_done(16'hC080, "sm128x127");
        release_op(16'hC080, "sm128x127");

        // Unsigned max and unsigned reading of the -3 pattern
        start_op(8'hFF, 8'hFF, 1'b0, "u255x255");
        wait_done(16'hFE01, "u255x255");
        release_op(16'hFE01, "u255x255");

        start_op(8'hFD, 8'h05, 1'b0, "uFDx05");
        wait_done(16'h04F1, "uFDx05");
        release_op(16'h04F1, "uFDx05");

        // Abort by reset during RUN iteration 4
        start_op(8'd200, 8'd100, 1'b0, "abort");
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort:in_ready", 32'(bus.in_ready), 32'd1);
        check("abort:out_valid", 32'(bus.out_valid), 32'd0);
        check("abort:busy", 32'(bus.busy), 32'd0);
        check("abort:prod", 32'(bus.prod), 32'h0000);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort:no_out_valid", 32'(seen), 32'd0);

        start_op(8'd7, 8'd9, 1'b0, "u7x9");
        wait_done(16'd63, "u7x9");
        release_op(16'd63, "u7x9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
